// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S receive path.
//   i2s_rx_state_t : slot tracking state of the receiver (IDLE, LEFT, RIGHT)
//   I2S_DW_DEFAULT : default number of bits captured per channel
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam int I2S_DW_DEFAULT = 24;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a bundle of asynchronous inputs.
// Ports:
//   clk     : destination clock
//   rst     : synchronous active-high reset, loads RST_VAL into both flops
//   d       : asynchronous inputs
//   q       : synchronised outputs (two clk cycles of latency)
// Parameters: WIDTH (bundle width), RST_VAL (per-bit reset value, default 0).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver. Oversamples sclk/lrclk/sdi in the clk domain,
// deserialises one left and one right word per frame MSB-first and emits
// the stereo pair with a single-cycle fifo write strobe.
// Ports:
//   clk       : audio clock, all logic on posedge
//   rst       : synchronous active-high reset
//   sclk      : I2S bit clock (asynchronous)
//   lrclk     : I2S word select, 0 = left, 1 = right (asynchronous)
//   sdi       : I2S serial data (asynchronous)
//   ldata     : captured left word, valid while wr_en = 1, held until next wr_en
//   rdata     : captured right word, valid while wr_en = 1, held until next wr_en
//   wr_en     : one-cycle write strobe per complete frame
//   frame_err : one-cycle pulse on a short slot
// Parameter: DW (bits captured per channel; extra slot bits are ignored).
// Optional feature: define I2S_RX_FRAME_CHECK_EN to drive frame_err;
// otherwise frame_err is tied low and short slots are silently dropped.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DW = I2S_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          lrclk,
  input  logic          sdi,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] rdata,
  output logic          wr_en,
  output logic          frame_err
);

  localparam int CW = $clog2(DW + 1);

  // ---- Stage p0: pin synchronisation and edge detection ----
  logic [2:0] pins_p0;
  logic       sclk_s, lrclk_s, sdi_s;

  // lrclk idles high so that reset does not fabricate a falling edge.
  sync_2ff #(
    .WIDTH  (3),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  ({sclk, lrclk, sdi}),
    .q  (pins_p0)
  );

  assign {sclk_s, lrclk_s, sdi_s} = pins_p0;

  logic sclk_prev, lrclk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev  <= 1'b0;
      lrclk_prev <= 1'b1;
    end else begin
      sclk_prev  <= sclk_s;
      lrclk_prev <= lrclk_s;
    end
  end

  logic sclk_rise, lr_rise, lr_fall, lr_edge;

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign lr_rise   = lrclk_s & ~lrclk_prev;
  assign lr_fall   = ~lrclk_s & lrclk_prev;
  assign lr_edge   = lr_rise | lr_fall;

  i2s_rx_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lr_fall) state_d = LEFT;
      LEFT:    if (lr_rise) state_d = RIGHT;
      RIGHT:   if (lr_fall) state_d = LEFT;
      default: state_d = IDLE;
    endcase
  end

  // ---- Stage p1: bit capture ----
  logic [CW-1:0] cnt_p1;
  logic          skip_p1;
  logic          vld_p1;
  logic [DW-1:0] shift_p1;
  logic          shift_en;
  logic          short_slot;

  assign shift_en   = sclk_rise && !lr_edge && (state_q != IDLE) && !skip_p1
                      && (cnt_p1 < CW'(DW));
  // The edge that leaves IDLE is never a short slot: nothing was being captured.
  assign short_slot = lr_edge && (state_q != IDLE) && (cnt_p1 < CW'(DW));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1  <= '0;
      skip_p1 <= 1'b1;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (lr_edge) begin
        cnt_p1  <= '0;
        // A coincident sclk rise is the one-bit delay slot, already consumed.
        skip_p1 <= ~sclk_rise;
      end else if (sclk_rise && state_q != IDLE) begin
        if (skip_p1) begin
          skip_p1 <= 1'b0;
        end else if (cnt_p1 < CW'(DW)) begin
          cnt_p1 <= cnt_p1 + CW'(1);
          vld_p1 <= (cnt_p1 == CW'(DW - 1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lr_edge)       shift_p1 <= '0;
    else if (shift_en) shift_p1 <= {shift_p1[DW-2:0], sdi_s};
  end

  // ---- Stage p2: word hold and output register ----
  logic [DW-1:0] left_hold;
  logic          left_ok;

  always_ff @(posedge clk) begin
    if (vld_p1 && state_q == LEFT) left_hold <= shift_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_ok <= 1'b0;
      wr_en   <= 1'b0;
      ldata   <= '0;
      rdata   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (short_slot) begin
        left_ok <= 1'b0;
      end else if (vld_p1) begin
        if (state_q == LEFT) begin
          left_ok <= 1'b1;
        end else if (state_q == RIGHT && left_ok) begin
          ldata   <= left_hold;
          rdata   <= shift_p1;
          wr_en   <= 1'b1;
          left_ok <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= short_slot;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
